timer_controller: RTL and testbench

- Sequences the mm:ss timer datapath that feeds the 4-digit multiplexed 7-segment display driver.
- Owns the run/pause/clear state machine, the 1 Hz tick prescaler, the display refresh enable, and BCD up/down counting of the four digits.
- Presets the count from user buttons and flags expiry in countdown mode.
- Outputs connect directly to the display driver's digit inputs and refresh clock input.

---
 rtl/timer_controller_pkg.sv | 83 ++++++++
 rtl/timer_controller_button.sv | 52 +++++
 rtl/timer_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_timer_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_controller_pkg.sv
// Shared types, limits and BCD field helpers for the mm:ss timer controller.
package timer_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } tc_state_t;

    // Single action selected per cycle from the accepted button presses
    typedef enum logic [2:0] {
        ACT_NONE       = 3'd0,
        ACT_CLEAR      = 3'd1,
        ACT_START_STOP = 3'd2,
        ACT_INC_MIN    = 3'd3,
        ACT_INC_SEC    = 3'd4,
        ACT_MODE       = 3'd5
    } tc_action_t;

    // Button indices, ordered from highest to lowest priority
    localparam int BTN_CLEAR      = 0;
    localparam int BTN_START_STOP = 1;
    localparam int BTN_INC_MIN    = 2;
    localparam int BTN_INC_SEC    = 3;
    localparam int BTN_MODE       = 4;
    localparam int BTN_COUNT      = 5;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_units;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
    } tc_time_t;

    localparam tc_time_t TIME_ZERO = 16'h0000;

    // Increment one 00-59 field; illegal digits collapse to 0
    function automatic logic [7:0] field_inc(input logic [3:0] tens, input logic [3:0] units);
        logic [3:0] t;
        logic [3:0] u;
        if (units >= UNITS_MAX) begin
            u = 4'd0;
            t = (tens >= TENS_MAX) ? 4'd0 : tens + 4'd1;
        end else begin
            u = units + 4'd1;
            t = (tens > TENS_MAX) ? 4'd0 : tens;
        end
        return {t, u};
    endfunction

    // Carry out of a 00-59 field on increment
    function automatic logic field_carry(input logic [3:0] tens, input logic [3:0] units);
        return (units >= UNITS_MAX) && (tens >= TENS_MAX);
    endfunction

    // Decrement one 00-59 field; illegal digits collapse to 0
    function automatic logic [7:0] field_dec(input logic [3:0] tens, input logic [3:0] units);
        logic [3:0] t;
        logic [3:0] u;
        if (units == 4'd0) begin
            u = UNITS_MAX;
            if (tens == 4'd0) begin
                t = TENS_MAX;
            end else begin
                t = (tens > TENS_MAX) ? 4'd0 : tens - 4'd1;
            end
        end else begin
            u = (units > UNITS_MAX) ? 4'd0 : units - 4'd1;
            t = (tens > TENS_MAX) ? 4'd0 : tens;
        end
        return {t, u};
    endfunction

    // Borrow out of a 00-59 field on decrement
    function automatic logic field_borrow(input logic [3:0] tens, input logic [3:0] units);
        return (units == 4'd0) && (tens == 4'd0);
    endfunction

endpackage

// File: rtl/timer_controller_button.sv
// Raw button conditioner: 2-FF synchronizer, stability counter, press pulse.
// The press pulse is registered and appears DEBOUNCE+2 edges after the raw edge.
module button_conditioner #(
    parameter int DEBOUNCE = 500000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [1:0]       sync_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn_raw};
        end
    end

    // Accept a new level only after it has been stable long enough; pulse on an accepted rise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            press_r  <= 1'b0;
        end else if (sync_r[1] != stable_r) begin
            if (cnt_r == CNT_LAST) begin
                stable_r <= sync_r[1];
                cnt_r    <= {CNT_W{1'b0}};
                press_r  <= sync_r[1];
            end else begin
                cnt_r    <= cnt_r + CNT_W'(1);
                press_r  <= 1'b0;
            end
        end else begin
            cnt_r   <= {CNT_W{1'b0}};
            press_r <= 1'b0;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/timer_controller.sv
// mm:ss timer sequencer feeding a 4-digit multiplexed 7-segment driver.
module timer_controller
    import timer_controller_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int REFRESH_DIV = 50000,
    parameter int DEBOUNCE    = 500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic       btn_inc_min,
    input  logic       btn_inc_sec,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       one_second,
    output logic       display_clock,
    output logic       running,
    output logic       count_down,
    output logic       expired
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

    logic [BTN_COUNT-1:0] btn_raw_s;
    logic [BTN_COUNT-1:0] press_s;
    tc_action_t           action_s;
    logic                 count_en_s;

    tc_state_t            state_r;
    tc_state_t            state_next_s;
    tc_time_t             time_r;
    tc_time_t             time_next_s;
    logic                 count_down_r;
    logic                 dir_next_s;
    logic [TICK_W-1:0]    presc_r;
    logic [TICK_W-1:0]    presc_next_s;
    logic                 tick_s;
    logic                 one_second_r;
    logic                 running_r;
    logic                 expired_r;
    logic [REF_W-1:0]     ref_cnt_r;
    logic                 display_clock_r;

    assign btn_raw_s[BTN_CLEAR]      = btn_clear;
    assign btn_raw_s[BTN_START_STOP] = btn_start_stop;
    assign btn_raw_s[BTN_INC_MIN]    = btn_inc_min;
    assign btn_raw_s[BTN_INC_SEC]    = btn_inc_sec;
    assign btn_raw_s[BTN_MODE]       = btn_mode;

    for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE(DEBOUNCE)
        ) u_cond (
            .clock  (clock),
            .reset_n(reset_n),
            .btn_raw(btn_raw_s[gi]),
            .press  (press_s[gi])
        );
    end

    // Highest-priority accepted press wins; other presses in the same cycle are dropped
    always_comb begin
        action_s = ACT_NONE;
        if (press_s[BTN_CLEAR]) begin
            action_s = ACT_CLEAR;
        end else if (press_s[BTN_START_STOP]) begin
            action_s = ACT_START_STOP;
        end else if (press_s[BTN_INC_MIN]) begin
            action_s = ACT_INC_MIN;
        end else if (press_s[BTN_INC_SEC]) begin
            action_s = ACT_INC_SEC;
        end else if (press_s[BTN_MODE]) begin
            action_s = ACT_MODE;
        end else begin
            action_s = ACT_NONE;
        end
    end

    // A clear or run/pause change this cycle takes precedence over the tick
    assign count_en_s = (state_r == ST_RUNNING) &&
                        (action_s != ACT_CLEAR) && (action_s != ACT_START_STOP);

    // Next state, next digits, prescaler and tick decision
    always_comb begin
        state_next_s = state_r;
        time_next_s  = time_r;
        dir_next_s   = count_down_r;
        presc_next_s = presc_r;
        tick_s       = 1'b0;
        case (action_s)
            ACT_CLEAR: begin
                state_next_s = ST_IDLE;
                time_next_s  = TIME_ZERO;
                presc_next_s = {TICK_W{1'b0}};
            end
            ACT_START_STOP: begin
                case (state_r)
                    ST_IDLE: begin
                        if (!count_down_r || (time_r != TIME_ZERO)) begin
                            state_next_s = ST_RUNNING;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end
                    ST_RUNNING: state_next_s = ST_PAUSED;
                    ST_PAUSED:  state_next_s = ST_RUNNING;
                    default:    state_next_s = state_r;
                endcase
            end
            ACT_INC_MIN: begin
                if ((state_r == ST_IDLE) || (state_r == ST_PAUSED)) begin
                    {time_next_s.min_tens, time_next_s.min_units} =
                        field_inc(time_r.min_tens, time_r.min_units);
                end else begin
                    time_next_s = time_r;
                end
            end
            ACT_INC_SEC: begin
                if ((state_r == ST_IDLE) || (state_r == ST_PAUSED)) begin
                    {time_next_s.sec_tens, time_next_s.sec_units} =
                        field_inc(time_r.sec_tens, time_r.sec_units);
                end else begin
                    time_next_s = time_r;
                end
            end
            ACT_MODE: begin
                if (state_r == ST_IDLE) begin
                    dir_next_s = ~count_down_r;
                end else begin
                    dir_next_s = count_down_r;
                end
            end
            default: begin
                state_next_s = state_r;
            end
        endcase

        if (count_en_s) begin
            if (presc_r == TICK_LAST) begin
                presc_next_s = {TICK_W{1'b0}};
                tick_s       = 1'b1;
                if (count_down_r) begin
                    {time_next_s.sec_tens, time_next_s.sec_units} =
                        field_dec(time_r.sec_tens, time_r.sec_units);
                    {time_next_s.min_tens, time_next_s.min_units} =
                        field_borrow(time_r.sec_tens, time_r.sec_units) ?
                        field_dec(time_r.min_tens, time_r.min_units) :
                        {time_r.min_tens, time_r.min_units};
                    if (time_next_s == TIME_ZERO) begin
                        state_next_s = ST_EXPIRED;
                    end else begin
                        state_next_s = ST_RUNNING;
                    end
                end else begin
                    {time_next_s.sec_tens, time_next_s.sec_units} =
                        field_inc(time_r.sec_tens, time_r.sec_units);
                    {time_next_s.min_tens, time_next_s.min_units} =
                        field_carry(time_r.sec_tens, time_r.sec_units) ?
                        field_inc(time_r.min_tens, time_r.min_units) :
                        {time_r.min_tens, time_r.min_units};
                end
            end else begin
                presc_next_s = presc_r + TICK_W'(1);
            end
        end else begin
            tick_s = 1'b0;
        end
    end

    // State, digits, direction, tick prescaler and registered status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            time_r       <= TIME_ZERO;
            count_down_r <= 1'b0;
            presc_r      <= {TICK_W{1'b0}};
            one_second_r <= 1'b0;
            running_r    <= 1'b0;
            expired_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            time_r       <= time_next_s;
            count_down_r <= dir_next_s;
            presc_r      <= presc_next_s;
            one_second_r <= tick_s;
            running_r    <= (state_next_s == ST_RUNNING);
            expired_r    <= (state_next_s == ST_EXPIRED);
        end
    end

    // Free-running display refresh enable, one cycle wide
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt_r       <= {REF_W{1'b0}};
            display_clock_r <= 1'b0;
        end else if (ref_cnt_r == REF_LAST) begin
            ref_cnt_r       <= {REF_W{1'b0}};
            display_clock_r <= 1'b1;
        end else begin
            ref_cnt_r       <= ref_cnt_r + REF_W'(1);
            display_clock_r <= 1'b0;
        end
    end

    assign sec_units     = time_r.sec_units;
    assign sec_tens      = time_r.sec_tens;
    assign min_units     = time_r.min_units;
    assign min_tens      = time_r.min_tens;
    assign one_second    = one_second_r;
    assign display_clock = display_clock_r;
    assign running       = running_r;
    assign count_down    = count_down_r;
    assign expired       = expired_r;

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller: directed scenarios plus random button traffic,
// compared every cycle against a total-seconds behavioural model.
module tb_timer_controller;

    localparam int TICK_DIV    = 10;
    localparam int REFRESH_DIV = 4;
    localparam int DEBOUNCE    = 3;
    localparam int PRESS_LAT   = 2 + DEBOUNCE + 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP  = 3;

    localparam int B_CLEAR = 0;
    localparam int B_START = 1;
    localparam int B_MIN   = 2;
    localparam int B_SEC   = 3;
    localparam int B_MODE  = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] btn = 5'b00000;
    logic [3:0] sec_units, sec_tens, min_units, min_tens;
    logic       one_second, display_clock, running, count_down, expired;
    logic [15:0] digits;

    assign digits = {min_tens, min_units, sec_tens, sec_units};

    timer_controller #(
        .TICK_DIV(TICK_DIV),
        .REFRESH_DIV(REFRESH_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .btn_start_stop(btn[B_START]),
        .btn_clear(btn[B_CLEAR]),
        .btn_mode(btn[B_MODE]),
        .btn_inc_min(btn[B_MIN]),
        .btn_inc_sec(btn[B_SEC]),
        .sec_units(sec_units),
        .sec_tens(sec_tens),
        .min_units(min_units),
        .min_tens(min_tens),
        .one_second(one_second),
        .display_clock(display_clock),
        .running(running),
        .count_down(count_down),
        .expired(expired)
    );

    always #5 clock = ~clock;

    // Model state: time kept as plain total seconds
    int cyc = 0;
    int ecount = 0;
    int m_state = M_IDLE;
    int m_secs = 0;
    int m_presc = 0;
    bit m_down = 1'b0;
    bit exp_tick = 1'b0;
    bit exp_disp = 1'b0;
    int sched [5];

    int checks = 0;
    int errors = 0;
    int sec_pulses = 0;
    int disp_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_state  = M_IDLE;
        m_secs   = 0;
        m_presc  = 0;
        m_down   = 1'b0;
        ecount   = 0;
        exp_tick = 1'b0;
        exp_disp = 1'b0;
        for (int b = 0; b < 5; b++) sched[b] = -1;
    endtask

    task automatic model_step();
        int act;
        cyc++;
        ecount++;
        exp_disp = ((ecount % REFRESH_DIV) == 0);
        exp_tick = 1'b0;
        act = -1;
        for (int b = 4; b >= 0; b--) begin
            if (sched[b] == cyc) begin
                act = b;
                sched[b] = -1;
            end
        end
        case (act)
            B_CLEAR: begin
                m_state = M_IDLE;
                m_secs  = 0;
                m_presc = 0;
            end
            B_START: begin
                case (m_state)
                    M_IDLE:  if (!m_down || m_secs != 0) m_state = M_RUN;
                    M_RUN:   m_state = M_PAUSE;
                    M_PAUSE: m_state = M_RUN;
                    default: ;
                endcase
            end
            B_MIN: if (m_state == M_IDLE || m_state == M_PAUSE)
                       m_secs = (((m_secs / 60) + 1) % 60) * 60 + (m_secs % 60);
            B_SEC: if (m_state == M_IDLE || m_state == M_PAUSE)
                       m_secs = (m_secs / 60) * 60 + ((m_secs % 60) + 1) % 60;
            B_MODE: if (m_state == M_IDLE) m_down = !m_down;
            default: ;
        endcase
        if (act != B_CLEAR && act != B_START && m_state == M_RUN) begin
            if (m_presc == TICK_DIV - 1) begin
                m_presc  = 0;
                exp_tick = 1'b1;
                if (m_down) begin
                    m_secs = (m_secs + 3599) % 3600;
                    if (m_secs == 0) m_state = M_EXP;
                end else begin
                    m_secs = (m_secs + 1) % 3600;
                end
            end else begin
                m_presc++;
            end
        end
    endtask

    // Model update on every active edge, and immediately on reset assertion
    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Compare DUT against the model on every falling edge
    initial begin
        forever begin
            @(negedge clock);
            chk("digits", digits, to_bcd(m_secs));
            chk("running", running, m_state == M_RUN);
            chk("expired", expired, m_state == M_EXP);
            chk("count_down", count_down, m_down);
            chk("one_second", one_second, exp_tick);
            chk("display_clock", display_clock, exp_disp);
            if (one_second) sec_pulses++;
            if (display_clock) disp_pulses++;
        end
    end

    task automatic press(input logic [4:0] mask);
        for (int b = 0; b < 5; b++) if (mask[b]) sched[b] = cyc + PRESS_LAT;
        btn = mask;
        repeat (8) @(negedge clock);
        btn = 5'b00000;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        logic [4:0] m;
        int r;
        #22 reset_n = 1'b1;
        sec_pulses = 0;
        disp_pulses = 0;

        // Idle after reset
        repeat (20) @(negedge clock);
        #1;
        chk("idle_digits", digits, 16'h0000);
        chk("idle_running", running, 1'b0);
        chk("idle_disp_pulses", disp_pulses, 5);
        chk("idle_sec_pulses", sec_pulses, 0);

        // Up count for 600 cycles, then pause
        sec_pulses = 0;
        press(5'b00010);
        repeat (590) @(negedge clock);
        #1;
        chk("up_digits", digits, 16'h0100);
        chk("up_pulses", sec_pulses, 60);
        chk("up_running", running, 1'b1);
        press(5'b00010);
        #1;
        chk("pause_running", running, 1'b0);
        repeat (50) @(negedge clock);
        #1;
        chk("pause_frozen", digits, 16'h0100);

        // Preset 01:05, count down to expiry
        press(5'b00001);
        press(5'b00100);
        repeat (5) press(5'b01000);
        press(5'b10000);
        #1;
        chk("preset_digits", digits, 16'h0105);
        chk("preset_down", count_down, 1'b1);
        press(5'b00010);
        repeat (630) @(negedge clock);
        #1;
        chk("down_64_digits", digits, 16'h0001);
        chk("down_64_expired", expired, 1'b0);
        repeat (10) @(negedge clock);
        #1;
        chk("down_65_digits", digits, 16'h0000);
        chk("down_65_expired", expired, 1'b1);
        chk("down_65_running", running, 1'b0);
        sec_pulses = 0;
        repeat (40) @(negedge clock);
        press(5'b00010);
        #1;
        chk("exp_hold_expired", expired, 1'b1);
        chk("exp_hold_digits", digits, 16'h0000);
        chk("exp_hold_pulses", sec_pulses, 0);

        // 59:59 wraps to 00:00 in up mode
        press(5'b00001);
        #1;
        chk("clear_keeps_dir", count_down, 1'b1);
        press(5'b10000);
        repeat (59) press(5'b00100);
        repeat (59) press(5'b01000);
        #1;
        chk("preset_5959", digits, 16'h5959);
        press(5'b00010);
        #1;
        chk("wrap_digits", digits, 16'h0000);
        chk("wrap_running", running, 1'b1);

        // Clear and start accepted together while running at 00:30
        press(5'b00001);
        press(5'b00010);
        repeat (290) @(negedge clock);
        #1;
        chk("at_0030", digits, 16'h0030);
        press(5'b00011);
        #1;
        chk("clr_start_digits", digits, 16'h0000);
        chk("clr_start_running", running, 1'b0);

        // Asynchronous reset mid-run
        press(5'b10000);
        press(5'b00100);
        press(5'b00010);
        repeat (55) @(negedge clock);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_digits", digits, 16'h0000);
        chk("arst_running", running, 1'b0);
        chk("arst_count_down", count_down, 1'b0);
        chk("arst_pulses", {one_second, display_clock, expired}, 3'b000);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        sec_pulses = 0;
        repeat (30) @(negedge clock);
        #1;
        chk("post_rst_running", running, 1'b0);
        chk("post_rst_digits", digits, 16'h0000);
        chk("post_rst_pulses", sec_pulses, 0);

        // Random button traffic against the model
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       m = 5'b00001;
                1, 2, 3: m = 5'b00010;
                4, 5:    m = 5'b00100;
                6, 7:    m = 5'b01000;
                8:       m = 5'b10000;
                default: m = 5'($urandom_range(1, 31));
            endcase
            press(m);
            repeat ($urandom_range(0, 120)) @(negedge clock);
        end

        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
